// File: rtl/softmax_div_seq.sv
// Softmax divide sequencer: latches a row denominator, streams N numerators through an
// external fixed-point divider and returns quotients on a backpressured stream.
module softmax_div_seq #(
  parameter int unsigned D_W      = 16,
  parameter int unsigned FRAC_BIT = 13,
  parameter int unsigned N        = 64,
  parameter int unsigned DIV_TO   = 8
) (
  input  logic           I_CLK,
  input  logic           I_RST_N,
  input  logic           I_START,
  input  logic [D_W-1:0] I_DENOM,
  input  logic           I_NUM_VLD,
  input  logic [D_W-1:0] I_NUM,
  output logic           O_NUM_RDY,
  output logic           O_DIV_START,
  output logic [D_W-1:0] O_DIVIDEND,
  output logic [D_W-1:0] O_DIVISOR,
  input  logic [D_W-1:0] I_DIV_QUOTIENT,
  input  logic           I_DIV_VLD,
  output logic           O_Q_VLD,
  output logic [D_W-1:0] O_Q,
  output logic           O_Q_LAST,
  input  logic           I_Q_RDY,
  output logic           O_BUSY,
  output logic           O_DONE,
  output logic [1:0]     O_ERR
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ToW  = (DIV_TO > 1) ? $clog2(DIV_TO) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(DIV_TO - 1);
  localparam logic [D_W-1:0]  SatPos  = {1'b0, {(D_W - 1){1'b1}}};
  localparam logic [D_W-1:0]  SatNeg  = {1'b1, {(D_W - 1){1'b0}}};

  // The fraction position only matters to the divider; reject nonsensical formats early.
  if (FRAC_BIT > D_W - 1) begin : g_bad_frac
    $error("FRAC_BIT must not exceed D_W-1");
  end

  typedef enum logic [2:0] {StIdle, StFetch, StDiv, StOut, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic [D_W-1:0]  denom_q, denom_d;
  logic [D_W-1:0]  dividend_q, dividend_d;
  logic [D_W-1:0]  divisor_q, divisor_d;
  logic [D_W-1:0]  q_q, q_d;
  logic [1:0]      err_q, err_d;

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      to_cnt_q   <= '0;
      denom_q    <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      q_q        <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      to_cnt_q   <= to_cnt_d;
      denom_q    <= denom_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      q_q        <= q_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    to_cnt_d   = to_cnt_q;
    denom_d    = denom_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    q_d        = q_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (I_START) begin
          denom_d = I_DENOM;
          cnt_d   = '0;
          err_d   = {1'b0, (I_DENOM == '0)};
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (I_NUM_VLD) begin
          dividend_d = I_NUM;
          divisor_d  = denom_q;
          to_cnt_d   = '0;
          if ((denom_q != '0) && (I_NUM != '0)) begin
            state_d = StDiv;
          end else begin
            // Zero numerator or zero denominator never reaches the divider.
            if (I_NUM == '0)        q_d = '0;
            else if (I_NUM[D_W-1])  q_d = SatNeg;
            else                    q_d = SatPos;
            state_d = StOut;
          end
        end
      end
      StDiv: begin
        // A quotient arriving on the final allowed cycle beats the timeout.
        if (I_DIV_VLD) begin
          q_d     = I_DIV_QUOTIENT;
          state_d = StOut;
        end else if (to_cnt_q == ToLast) begin
          q_d      = '0;
          err_d[1] = 1'b1;
          state_d  = StOut;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StOut: begin
        if (I_Q_RDY) begin
          if (cnt_q == CntLast) begin
            state_d = StDone;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign O_NUM_RDY   = (state_q == StFetch);
  assign O_DIV_START = (state_q == StDiv);
  assign O_DIVIDEND  = dividend_q;
  assign O_DIVISOR   = divisor_q;
  assign O_Q_VLD     = (state_q == StOut);
  assign O_Q         = q_q;
  assign O_Q_LAST    = (state_q == StOut) && (cnt_q == CntLast);
  assign O_BUSY      = (state_q != StIdle);
  assign O_DONE      = (state_q == StDone);
  assign O_ERR       = err_q;

endmodule

// File: tb/tb_softmax_div_seq.sv
// Randomized self-checking bench for softmax_div_seq with a behavioural divider stub
// and a sign-magnitude fixed-point reference.
module tb_softmax_div_seq;
  localparam int D_W = 16, FRAC_BIT = 13, N = 3, DIV_TO = 8;

  logic        I_CLK = 1'b0, I_RST_N = 1'b0;
  logic        I_START = 1'b0, I_NUM_VLD = 1'b0, I_Q_RDY = 1'b0;
  logic [15:0] I_DENOM = '0, I_NUM = '0;
  logic [15:0] I_DIV_QUOTIENT = 16'hDEAD;
  logic        I_DIV_VLD, stub_vld = 1'b0, spur_vld = 1'b0;
  logic        O_NUM_RDY, O_DIV_START, O_Q_VLD, O_Q_LAST, O_BUSY, O_DONE;
  logic [15:0] O_DIVIDEND, O_DIVISOR, O_Q;
  logic [1:0]  O_ERR;

  int checks = 0, errors = 0;
  int div_lat = 5;
  int scnt = 0;

  softmax_div_seq #(.D_W(D_W), .FRAC_BIT(FRAC_BIT), .N(N), .DIV_TO(DIV_TO)) dut (
    .I_CLK(I_CLK), .I_RST_N(I_RST_N), .I_START(I_START), .I_DENOM(I_DENOM),
    .I_NUM_VLD(I_NUM_VLD), .I_NUM(I_NUM), .O_NUM_RDY(O_NUM_RDY),
    .O_DIV_START(O_DIV_START), .O_DIVIDEND(O_DIVIDEND), .O_DIVISOR(O_DIVISOR),
    .I_DIV_QUOTIENT(I_DIV_QUOTIENT), .I_DIV_VLD(I_DIV_VLD), .O_Q_VLD(O_Q_VLD), .O_Q(O_Q),
    .O_Q_LAST(O_Q_LAST), .I_Q_RDY(I_Q_RDY), .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_ERR(O_ERR)
  );

  always #5 I_CLK = ~I_CLK;
  assign I_DIV_VLD = stub_vld | spur_vld;

  // Sign-magnitude divide: |n| * 2^FRAC / |d|, saturated, sign = xor.
  function automatic logic [15:0] div_model(input logic [15:0] n, input logic [15:0] d);
    longint unsigned mag;
    if (d[14:0] == 15'd0) mag = 64'h7FFF;
    else mag = (longint'(n[14:0]) << FRAC_BIT) / longint'(d[14:0]);
    if (mag > 64'h7FFF) mag = 64'h7FFF;
    return {n[15] ^ d[15], mag[14:0]};
  endfunction

  function automatic logic [15:0] ref_q(input logic [15:0] n, input logic [15:0] d,
                                        input int lat);
    if (n == 16'h0) return 16'h0;
    if (d == 16'h0) return n[15] ? 16'h8000 : 16'h7FFF;
    if (lat == 0 || lat > DIV_TO) return 16'h0;
    return div_model(n, d);
  endfunction

  // Divider stub: pulses VLD on the div_lat-th cycle of start (0 = never answers).
  always @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      scnt = 0;
      stub_vld = 1'b0;
      I_DIV_QUOTIENT = 16'hDEAD;
    end else begin
      #1;
      if (O_DIV_START === 1'b1) scnt++;
      else scnt = 0;
      stub_vld = (div_lat != 0) && (O_DIV_START === 1'b1) && (scnt == div_lat);
      I_DIV_QUOTIENT = stub_vld ? div_model(O_DIVIDEND, O_DIVISOR) : 16'hDEAD;
    end
  end

  task automatic tick;
    @(posedge I_CLK);
    #2;
  endtask

  task automatic run_row(input logic [15:0] denom, input logic [15:0] nums [N],
                         input int lat, input int bp, input bit noise);
    int cyc, starts, pre, elat;
    bit exp_div, ok;
    logic [15:0] hq, eq;
    logic [1:0] eerr;
    div_lat = lat;
    eerr = {1'b0, denom == 16'h0};
    I_DENOM = denom;
    I_START = 1'b1;
    tick;
    I_START = 1'b0;
    I_DENOM = 16'($urandom);
    checks++;
    if (O_BUSY !== 1'b1 || O_ERR !== eerr) begin
      errors++;
      $display("FAIL row_start busy=%b err=%b want busy=1 err=%b", O_BUSY, O_ERR, eerr);
    end
    for (int e = 0; e < N; e++) begin
      cyc = 0;
      while (O_NUM_RDY !== 1'b1 && cyc < 20) begin tick; cyc++; end
      checks++;
      if (O_NUM_RDY !== 1'b1) begin
        errors++;
        $display("FAIL num_rdy e%0d got %b want 1", e, O_NUM_RDY);
      end
      I_NUM_VLD = 1'b1;
      I_NUM = nums[e];
      tick;
      I_NUM_VLD = 1'b0;
      I_NUM = 16'($urandom);
      exp_div = (denom != 16'h0) && (nums[e] != 16'h0);
      elat = !exp_div ? 0 : (lat == 0 || lat > DIV_TO) ? DIV_TO : lat;
      if (exp_div && (lat == 0 || lat > DIV_TO)) eerr[1] = 1'b1;
      cyc = 0; starts = 0; pre = 0; ok = 1'b1;
      while (O_Q_VLD !== 1'b1 && cyc < 40) begin
        if (O_DIV_START === 1'b1) begin
          starts++;
          if (I_DIV_VLD !== 1'b1) pre++;
          if (O_DIVIDEND !== nums[e] || O_DIVISOR !== denom) ok = 1'b0;
        end
        tick;
        cyc++;
      end
      checks++;
      if (cyc != elat) begin
        errors++;
        $display("FAIL q_latency e%0d got %0d cycles want %0d", e, cyc, elat);
      end
      checks++;
      if (starts != elat || pre != ((exp_div && elat == lat) ? lat - 1 : elat)) begin
        errors++;
        $display("FAIL start_len e%0d got %0d (%0d before vld) want %0d", e, starts, pre, elat);
      end
      checks++;
      if (!ok || O_DIVIDEND !== nums[e] || O_DIVISOR !== denom) begin
        errors++;
        $display("FAIL operands e%0d got %h/%h want %h/%h", e, O_DIVIDEND, O_DIVISOR,
                 nums[e], denom);
      end
      hq = O_Q;
      ok = 1'b1;
      for (int b = 0; b < bp; b++) begin
        if (noise) begin I_START = 1'b1; I_DENOM = 16'h0; end
        tick;
        if (O_Q_VLD !== 1'b1 || O_Q !== hq || O_NUM_RDY !== 1'b0 || O_DIV_START !== 1'b0)
          ok = 1'b0;
      end
      I_START = 1'b0;
      if (bp > 0) begin
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL backpressure_hold e%0d q=%h vld=%b rdy=%b start=%b want q=%h held",
                   e, O_Q, O_Q_VLD, O_NUM_RDY, O_DIV_START, hq);
        end
      end
      eq = ref_q(nums[e], denom, lat);
      checks++;
      if (O_Q !== eq || O_Q_LAST !== (e == N - 1)) begin
        errors++;
        $display("FAIL quotient e%0d got q=%h last=%b want q=%h last=%b", e, O_Q, O_Q_LAST,
                 eq, (e == N - 1));
      end
      I_Q_RDY = 1'b1;
      tick;
      I_Q_RDY = 1'b0;
      checks++;
      if (O_DONE !== (e == N - 1) || O_Q_VLD !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse e%0d got done=%b vld=%b want done=%b vld=0", e, O_DONE,
                 O_Q_VLD, (e == N - 1));
      end
    end
    tick;
    checks++;
    if (O_BUSY !== 1'b0 || O_DONE !== 1'b0 || O_ERR !== eerr) begin
      errors++;
      $display("FAIL row_end busy=%b done=%b err=%b want busy=0 done=0 err=%b", O_BUSY,
               O_DONE, O_ERR, eerr);
    end
  endtask

  task automatic test_reset;
    repeat (2) tick;
    checks++;
    if ({O_NUM_RDY, O_DIV_START, O_DIVIDEND, O_DIVISOR, O_Q_VLD, O_Q, O_Q_LAST, O_BUSY,
         O_DONE, O_ERR} !== '0) begin
      errors++;
      $display("FAIL reset_state some output nonzero q=%h busy=%b err=%b want all 0", O_Q,
               O_BUSY, O_ERR);
    end
    I_RST_N = 1'b1;
    tick;
  endtask

  task automatic test_unit_denom;
    logic [15:0] nums [N];
    nums = '{16'h1000, 16'h0800, 16'hE000};
    run_row(16'h2000, nums, 5, 0, 1'b0);
  endtask

  task automatic test_zero_denom;
    logic [15:0] nums [N];
    nums = '{16'h0100, 16'h8100, 16'h0000};
    run_row(16'h0000, nums, 5, 0, 1'b0);
  endtask

  task automatic test_latency;
    logic [15:0] nums [N];
    nums = '{16'h0C00, 16'h9234, 16'h1FFF};
    run_row(16'h1800, nums, 5, 0, 1'b0);
    run_row(16'h8300, nums, 1, 0, 1'b0);
  endtask

  task automatic test_backpressure;
    logic [15:0] nums [N];
    nums = '{16'h0400, 16'h0000, 16'hC000};
    run_row(16'h2800, nums, 5, 10, 1'b1);
  endtask

  task automatic test_timeout;
    logic [15:0] nums [N];
    nums = '{16'h0200, 16'h8800, 16'h0300};
    run_row(16'h2000, nums, 0, 0, 1'b0);
    run_row(16'h2000, nums, DIV_TO, 1, 1'b0);
  endtask

  task automatic test_spurious_vld;
    logic [15:0] hq;
    hq = O_Q;
    spur_vld = 1'b1;
    tick;
    spur_vld = 1'b0;
    tick;
    checks++;
    if (O_Q_VLD !== 1'b0 || O_BUSY !== 1'b0 || O_Q !== hq) begin
      errors++;
      $display("FAIL spurious_vld got vld=%b busy=%b q=%h want 0/0/%h", O_Q_VLD, O_BUSY,
               O_Q, hq);
    end
  endtask

  task automatic test_reset_mid_row;
    logic [15:0] nums [N];
    div_lat = 0;
    I_DENOM = 16'h2000;
    I_START = 1'b1;
    tick;
    I_START = 1'b0;
    I_NUM_VLD = 1'b1;
    I_NUM = 16'h1000;
    tick;
    I_NUM_VLD = 1'b0;
    repeat (2) tick;
    checks++;
    if (O_DIV_START !== 1'b1) begin
      errors++;
      $display("FAIL mid_row_in_div got start=%b want 1", O_DIV_START);
    end
    I_RST_N = 1'b0;
    #1;
    checks++;
    if ({O_NUM_RDY, O_DIV_START, O_DIVIDEND, O_DIVISOR, O_Q_VLD, O_Q, O_Q_LAST, O_BUSY,
         O_DONE, O_ERR} !== '0) begin
      errors++;
      $display("FAIL mid_row_reset start=%b busy=%b dividend=%h want all 0", O_DIV_START,
               O_BUSY, O_DIVIDEND);
    end
    tick;
    I_RST_N = 1'b1;
    tick;
    nums = '{16'h0A00, 16'hF000, 16'h0001};
    run_row(16'h3000, nums, 5, 2, 1'b0);
  endtask

  task automatic test_random;
    logic [15:0] nums [N];
    logic [15:0] denom;
    int lat;
    for (int r = 0; r < 8; r++) begin
      denom = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom_range(1, 16'hFFFF));
      for (int i = 0; i < N; i++)
        nums[i] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      lat = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, DIV_TO));
      run_row(denom, nums, lat, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset;
    test_unit_denom;
    test_zero_denom;
    test_latency;
    test_backpressure;
    test_timeout;
    test_spurious_vld;
    test_reset_mid_row;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
